ins_mem_controller: RTL and testbench

INS_MEM_CONTROLLER -- requirements
Module: ins_mem_controller

---
 rtl/ins_mem_pkg.sv | 19 +
 rtl/ins_mem_controller_rr_arb2.sv | 31 +++
 rtl/ins_mem_controller.sv | 110 +++++++++++
 tb/tb_ins_mem_controller.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_mem_pkg.sv
// Shared parameters, state encoding and arbitration tags for the instruction memory controller.
package ins_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    typedef enum logic {
        WIN_FETCH = 1'b0,
        WIN_LOAD  = 1'b1
    } winner_e;

endpackage

// File: rtl/ins_mem_controller_rr_arb2.sv
// Two-way round-robin arbiter between fetch and load; purely combinational.
module rr_arb2
    import ins_mem_pkg::*;
(
    input  logic    enable,
    input  logic    fetch_req,
    input  logic    load_req,
    input  winner_e last_win,
    output logic    fetch_gnt,
    output logic    load_gnt
);

    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (enable) begin
            // On a conflict the requester that did not win last time goes first.
            if (fetch_req && load_req) begin
                if (last_win == WIN_LOAD) begin
                    fetch_gnt = 1'b1;
                end else begin
                    load_gnt = 1'b1;
                end
            end else begin
                fetch_gnt = fetch_req;
                load_gnt  = load_req;
            end
        end
    end

endmodule

// File: rtl/ins_mem_controller.sv
// Instruction memory port controller: arbitrates instruction fetches against
// program-load writes and returns fetched words through a valid/ready handshake.
module ins_mem_controller
    import ins_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] FetchAddr,
    output logic              FetchGnt,
    output logic              FetchValid,
    output logic [DATA_W-1:0] FetchData,
    input  logic              FetchReady,
    input  logic              LoadReq,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic [BE_W-1:0]   LoadBe,
    output logic              LoadGnt,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemEna,
    output logic [BE_W-1:0]   MemWea,
    output logic [DATA_W-1:0] MemDin,
    input  logic [DATA_W-1:0] MemDout,
    output logic              Busy
);

    state_e            state_q, state_d;
    winner_e           last_win_q, last_win_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              arb_en;
    logic              fetch_gnt, load_gnt;

    assign arb_en = (state_q == IDLE);

    rr_arb2 u_arb (
        .enable    (arb_en),
        .fetch_req (FetchReq),
        .load_req  (LoadReq),
        .last_win  (last_win_q),
        .fetch_gnt (fetch_gnt),
        .load_gnt  (load_gnt)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            last_win_q   <= WIN_FETCH;
            fetch_data_q <= '0;
        end else begin
            state_q      <= state_d;
            last_win_q   <= last_win_d;
            fetch_data_q <= fetch_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_win_d   = last_win_q;
        fetch_data_d = fetch_data_q;
        case (state_q)
            IDLE: begin
                if (fetch_gnt) begin
                    state_d    = RD_WAIT;
                    last_win_d = WIN_FETCH;
                end else if (load_gnt) begin
                    last_win_d = WIN_LOAD;
                end
            end
            RD_WAIT: begin
                fetch_data_d = MemDout;
                state_d      = RESP;
            end
            RESP: begin
                if (FetchReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are qualified with reset so the memory port stays quiet while
    // reset is held, even if requesters keep their requests up.
    assign FetchGnt = fetch_gnt & Rst_n;
    assign LoadGnt  = load_gnt & Rst_n;

    always_comb begin
        MemAddr = '0;
        MemEna  = 1'b0;
        MemWea  = '0;
        MemDin  = '0;
        if (FetchGnt) begin
            MemEna  = 1'b1;
            MemAddr = FetchAddr;
        end else if (LoadGnt) begin
            MemEna  = 1'b1;
            MemAddr = LoadAddr;
            MemWea  = LoadBe;
            MemDin  = LoadData;
        end
    end

    assign FetchValid = (state_q == RESP);
    assign FetchData  = fetch_data_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ins_mem_controller.sv
// Scoreboard bench for ins_mem_controller: directed scenarios plus random
// fetch/load traffic checked against a word-level memory and arbitration model.
module tb_ins_mem_controller;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        bit            is_load;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] data;
    } grant_t;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          FetchReq, LoadReq, FetchReady;
    logic [AW-1:0] FetchAddr, LoadAddr, MemAddr;
    logic [DW-1:0] LoadData, FetchData, MemDin, MemDout;
    logic [3:0]    LoadBe, MemWea;
    logic          FetchGnt, FetchValid, LoadGnt, MemEna, Busy;

    always #5 Clk = ~Clk;

    ins_mem_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
        .FetchValid(FetchValid), .FetchData(FetchData), .FetchReady(FetchReady),
        .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadBe(LoadBe),
        .LoadGnt(LoadGnt), .MemAddr(MemAddr), .MemEna(MemEna), .MemWea(MemWea),
        .MemDin(MemDin), .MemDout(MemDout), .Busy(Busy)
    );

    grant_t        exp_grant_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            grant_cyc_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    bit            mon_en = 0;
    bit            ready_mode = 0;
    logic          ready_val = 1'b1;
    bit            next_conflict_load = 1;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    grant_t        mon_g;
    bit            pending = 0;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 3)  return 32'h8C220004;
        if (i == 32) return 32'h12345678;
        return 32'hA5000000 ^ (32'(i) * 32'h9E3779B1);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory behaviour: synchronous read with one cycle latency, byte-enabled write.
    initial begin
        MemDout = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = init_word(i);
        forever begin
            @(posedge Clk);
            if (MemEna) begin
                if (MemWea == 4'b0000) MemDout <= mem[MemAddr];
                else for (int b = 0; b < 4; b++)
                    if (MemWea[b]) mem[MemAddr][8*b +: 8] = MemDin[8*b +: 8];
            end
        end
    end

    initial begin
        FetchReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            FetchReady = ready_mode ? ($urandom_range(0, 2) != 0) : ready_val;
        end
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: pops expected grants and fetch responses as the DUT presents them.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                exp_grant_q.delete();
                exp_data_q.delete();
                grant_cyc_q.delete();
                pending = 0;
            end else if (mon_en) begin
                if (FetchGnt || LoadGnt) begin
                    checkOutput("single_grant", 64'(FetchGnt & LoadGnt), 64'd0);
                    checkOutput("grant_only_idle", 64'(Busy), 64'd0);
                    if (FetchGnt) grant_cyc_q.push_back(cyc);
                    if (exp_grant_q.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_grant: fetch=%0b load=%0b, expected no grant", FetchGnt, LoadGnt);
                    end else begin
                        mon_g = exp_grant_q.pop_front();
                        checkOutput("grant_kind_is_load", 64'(LoadGnt), 64'(mon_g.is_load));
                        checkOutput("mem_ena", 64'(MemEna), 64'd1);
                        checkOutput("mem_addr", 64'(MemAddr), 64'(mon_g.addr));
                        if (mon_g.is_load) begin
                            checkOutput("mem_wea", 64'(MemWea), 64'(mon_g.be));
                            checkOutput("mem_din", 64'(MemDin), 64'(mon_g.data));
                        end else begin
                            checkOutput("mem_wea_read", 64'(MemWea), 64'd0);
                        end
                    end
                end else begin
                    checkOutput("idle_mem_port", 64'({MemEna, MemWea, MemAddr, MemDin}), 64'd0);
                end
                if (pending) checkOutput("valid_held", 64'(FetchValid), 64'd1);
                if (FetchValid) begin
                    if (!pending) begin
                        if (grant_cyc_q.size() == 0) begin
                            checks++; errors++;
                            $display("[TB] FAIL unexpected_valid: FetchValid=1 with no fetch granted");
                        end else begin
                            checkOutput("fetch_latency", 64'(cyc - grant_cyc_q.pop_front()), 64'd2);
                        end
                    end
                    if (exp_data_q.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_data: FetchData=0x%0h with nothing expected", FetchData);
                    end else begin
                        checkOutput("fetch_data", 64'(FetchData), 64'(exp_data_q[0]));
                    end
                    if (FetchReady) begin
                        if (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
                        pending = 0;
                    end else begin
                        pending = 1;
                    end
                end else begin
                    pending = 0;
                end
            end
        end
    end

    task automatic push_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        exp_grant_q.push_back('{is_load: 1'b1, addr: a, be: be, data: d});
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic push_fetch(input logic [AW-1:0] a);
        exp_grant_q.push_back('{is_load: 1'b0, addr: a, be: 4'h0, data: '0});
        exp_data_q.push_back(ref_mem[a]);
    endtask

    // Issues a load, a fetch, or both at once, and waits for every grant.
    task automatic applyStimulus(input bit do_load, input bit do_fetch, input logic [AW-1:0] la,
                                 input logic [DW-1:0] ld, input logic [3:0] lbe, input logic [AW-1:0] fa);
        bit load_first;
        bit lg_seen = 0;
        bit fg_seen = 0;
        bit lg, fg;
        load_first = do_load && (!do_fetch || next_conflict_load);
        if (do_load && load_first)  push_load(la, ld, lbe);
        if (do_fetch)               push_fetch(fa);
        if (do_load && !load_first) push_load(la, ld, lbe);
        next_conflict_load = load_first ? do_fetch : !do_load;
        @(posedge Clk);
        #1;
        LoadAddr = la; LoadData = ld; LoadBe = lbe; FetchAddr = fa;
        LoadReq = do_load; FetchReq = do_fetch;
        for (int i = 0; i < 60 && !((lg_seen || !do_load) && (fg_seen || !do_fetch)); i++) begin
            @(negedge Clk);
            fg = FetchGnt; lg = LoadGnt;
            @(posedge Clk);
            #1;
            if (fg && do_fetch) begin fg_seen = 1; FetchReq = 1'b0; end
            if (lg && do_load)  begin lg_seen = 1; LoadReq = 1'b0; end
        end
        checkOutput("grants_within_budget", 64'({lg_seen || !do_load, fg_seen || !do_fetch}), 64'd3);
        FetchReq = 1'b0; LoadReq = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge Clk);
            done = (exp_grant_q.size() == 0) && (exp_data_q.size() == 0) && !Busy && !FetchValid;
        end
        checkOutput("drain_within_budget", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_fetch_gnt"}, 64'(FetchGnt), 64'd0);
        checkOutput({tag, "_load_gnt"}, 64'(LoadGnt), 64'd0);
        checkOutput({tag, "_fetch_valid"}, 64'(FetchValid), 64'd0);
        checkOutput({tag, "_fetch_data"}, 64'(FetchData), 64'd0);
        checkOutput({tag, "_mem_port"}, 64'({MemEna, MemWea, MemAddr, MemDin}), 64'd0);
        checkOutput({tag, "_busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int vcnt, vseen, ng, acc_cyc, lg_cyc;
        bit got;
        Rst_n = 1'b0;
        FetchReq = 1'b0; LoadReq = 1'b0;
        FetchAddr = '0; LoadAddr = '0; LoadData = '0; LoadBe = '0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);

        #2;
        FetchReq = 1'b1; LoadReq = 1'b1; FetchAddr = 12'h005; LoadAddr = 12'h007; LoadBe = 4'hF;
        #1;
        check_all_zero("reset");
        FetchReq = 1'b0; LoadReq = 1'b0;
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 1'b1;
        mon_en = 1;

        // Basic fetch of a preloaded word.
        applyStimulus(0, 1, '0, '0, '0, 12'h003);
        wait_idle();

        // Full-word load followed by a fetch of the same address.
        applyStimulus(1, 0, 12'h010, 32'hDEADBEEF, 4'hF, '0);
        applyStimulus(0, 1, '0, '0, '0, 12'h010);
        wait_idle();

        // Load with no byte enables leaves the word untouched.
        applyStimulus(1, 0, 12'h020, 32'hCAFEF00D, 4'h0, '0);
        applyStimulus(0, 1, '0, '0, '0, 12'h020);
        wait_idle();

        // Consumer stall in RESP with a load waiting behind it.
        ready_val = 1'b0;
        applyStimulus(0, 1, '0, '0, '0, 12'h040);
        push_load(12'h041, 32'h5A5A1234, 4'hF);
        next_conflict_load = 0;
        LoadAddr = 12'h041; LoadData = 32'h5A5A1234; LoadBe = 4'hF; LoadReq = 1'b1;
        vcnt = 0; got = 0; acc_cyc = -10; lg_cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clk);
            if (FetchValid && !FetchReady) begin
                vcnt++;
                if (vcnt == 5) ready_val = 1'b1;
            end
            if (FetchValid && FetchReady) acc_cyc = cyc;
            if (LoadGnt) begin got = 1; lg_cyc = cyc; end
        end
        @(posedge Clk);
        #1;
        LoadReq = 1'b0;
        checkOutput("stall_valid_cycles", 64'(vcnt), 64'd5);
        checkOutput("stall_load_gnt_seen", 64'(got), 64'd1);
        checkOutput("stall_load_gnt_delay", 64'(lg_cyc - acc_cyc), 64'd1);
        wait_idle();

        // Reset while a fetch is in RD_WAIT abandons it.
        applyStimulus(0, 1, '0, '0, '0, 12'h003);
        #2;
        Rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        next_conflict_load = 1;
        @(negedge Clk);
        @(posedge Clk);
        #3;
        Rst_n = 1'b1;
        vseen = 0;
        repeat (10) begin
            @(negedge Clk);
            if (FetchValid) vseen++;
        end
        checkOutput("no_valid_after_reset", 64'(vseen), 64'd0);

        // Both requests held across three contests: Load, Fetch, Load.
        push_load(12'h050, 32'h0BADC0DE, 4'hF);
        push_fetch(12'h060);
        push_load(12'h050, 32'h0BADC0DE, 4'hF);
        next_conflict_load = 0;
        @(posedge Clk);
        #1;
        LoadAddr = 12'h050; LoadData = 32'h0BADC0DE; LoadBe = 4'hF; FetchAddr = 12'h060;
        LoadReq = 1'b1; FetchReq = 1'b1;
        ng = 0;
        for (int i = 0; i < 60 && ng < 3; i++) begin
            @(negedge Clk);
            if (FetchGnt || LoadGnt) ng++;
        end
        @(posedge Clk);
        #1;
        LoadReq = 1'b0; FetchReq = 1'b0;
        checkOutput("contest_grant_count", 64'(ng), 64'd3);
        wait_idle();

        // Random traffic with a random consumer.
        ready_mode = 1;
        repeat (40) begin
            int kind;
            logic [AW-1:0] la, fa;
            kind = $urandom_range(0, 2);
            la = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            fa = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) fa = 12'hFFF;
            applyStimulus(kind != 1, kind != 0, la, $urandom, 4'($urandom_range(0, 15)), fa);
        end
        wait_idle();
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
